serial_frame_tx: RTL



---
 rtl/serial_frame_tx.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/serial_frame_tx.sv
// Parallel-to-serial frame transmitter: start bit, LSB-first data, optional parity, stop bit.
// Ready also rises in the final stop-bit cycle so a held Load chains frames with no idle gap.
module serial_frame_tx #(
  parameter int unsigned DATA_BITS    = 8,
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned PARITY       = 0
) (
  input  logic                 Clk,
  input  logic                 notReset,
  input  logic [DATA_BITS-1:0] D,
  input  logic                 Load,
  output logic                 Ready,
  output logic                 Tx,
  output logic                 Busy,
  output logic                 Done
);

  localparam int unsigned CntW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BitW = $clog2(DATA_BITS);
  localparam logic [CntW-1:0] LastCyc = CntW'(CLKS_PER_BIT - 1);
  localparam logic [BitW-1:0] LastBit = BitW'(DATA_BITS - 1);

  if (DATA_BITS < 5 || DATA_BITS > 16) begin : genBadDataBits
    $error("serial_frame_tx: DATA_BITS must be 5..16");
  end
  if (CLKS_PER_BIT < 2) begin : genBadClksPerBit
    $error("serial_frame_tx: CLKS_PER_BIT must be >= 2");
  end
  if (PARITY > 2) begin : genBadParity
    $error("serial_frame_tx: PARITY must be 0, 1 or 2");
  end

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StParity,
    StStop
  } stateT;

  stateT                stateQ, stateD;
  logic [DATA_BITS-1:0] shiftQ, shiftD;
  logic [BitW-1:0]      bitCntQ, bitCntD;
  logic [CntW-1:0]      cycCntQ, cycCntD;
  logic                 parityQ, parityD;
  logic                 txQ, txD;
  logic                 doneQ, doneD;
  logic                 lastCyc;
  logic                 accept;

  assign lastCyc = (cycCntQ == LastCyc);

  always_comb begin
    Ready = (stateQ == StIdle) || ((stateQ == StStop) && lastCyc);
    Busy  = (stateQ != StIdle);
    Tx    = txQ;
    Done  = doneQ;
  end

  assign accept = Load && Ready;

  always_comb begin
    stateD  = stateQ;
    shiftD  = shiftQ;
    bitCntD = bitCntQ;
    cycCntD = lastCyc ? '0 : cycCntQ + CntW'(1);
    parityD = parityQ;
    txD     = txQ;
    doneD   = 1'b0;

    case (stateQ)
      StIdle: begin
        cycCntD = '0;
        bitCntD = '0;
        txD     = 1'b1;
      end
      StStart: begin
        if (lastCyc) begin
          stateD = StData;
          txD    = shiftQ[0];
        end
      end
      StData: begin
        if (lastCyc) begin
          shiftD = shiftQ >> 1;
          if (bitCntQ == LastBit) begin
            bitCntD = '0;
            if (PARITY != 0) begin
              stateD = StParity;
              txD    = parityQ;
            end else begin
              stateD = StStop;
              txD    = 1'b1;
            end
          end else begin
            bitCntD = bitCntQ + BitW'(1);
            txD     = shiftD[0];
          end
        end
      end
      StParity: begin
        if (lastCyc) begin
          stateD = StStop;
          txD    = 1'b1;
        end
      end
      StStop: begin
        if (lastCyc) begin
          stateD = StIdle;
          txD    = 1'b1;
          doneD  = 1'b1;
        end
      end
      default: begin
        stateD  = StIdle;
        cycCntD = '0;
        bitCntD = '0;
        txD     = 1'b1;
      end
    endcase

    // Capture overrides whatever the current state chose; parity is frozen from the captured word.
    if (accept) begin
      stateD  = StStart;
      shiftD  = D;
      parityD = (PARITY == 2) ? ~(^D) : (^D);
      cycCntD = '0;
      bitCntD = '0;
      txD     = 1'b0;
    end
  end

  always_ff @(posedge Clk) begin
    if (!notReset) begin
      stateQ  <= StIdle;
      shiftQ  <= '0;
      bitCntQ <= '0;
      cycCntQ <= '0;
      parityQ <= 1'b0;
      txQ     <= 1'b1;
      doneQ   <= 1'b0;
    end else begin
      stateQ  <= stateD;
      shiftQ  <= shiftD;
      bitCntQ <= bitCntD;
      cycCntQ <= cycCntD;
      parityQ <= parityD;
      txQ     <= txD;
      doneQ   <= doneD;
    end
  end

endmodule
